// File: rtl/cpu_pkg.sv
// Shared constants for the CPU control unit.
//  - Opcode encodings (3-bit base; wider opcode fields zero-extend these).
//  - Phase constants for the 8-phase instruction cycle.
package cpu_pkg;

  localparam int PHASE_W = 3;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [PHASE_W-1:0] PH_FETCH0 = 3'd0;
  localparam logic [PHASE_W-1:0] PH_FETCH1 = 3'd1;
  localparam logic [PHASE_W-1:0] PH_FETCH2 = 3'd2;
  localparam logic [PHASE_W-1:0] PH_FETCH3 = 3'd3;
  localparam logic [PHASE_W-1:0] PH_EXEC4  = 3'd4;
  localparam logic [PHASE_W-1:0] PH_EXEC5  = 3'd5;
  localparam logic [PHASE_W-1:0] PH_EXEC6  = 3'd6;
  localparam logic [PHASE_W-1:0] PH_EXEC7  = 3'd7;

endpackage

// File: rtl/phase_sequencer.sv
// Phase counter plus run-control state for the CPU control unit.
// Ports:
//  clk, rst     clock, async active-high reset
//  en           run enable
//  step_mode    stop at phase 0 until step
//  step         release one instruction in step_mode
//  resume       clears halted
//  mem_req      current phase issues a memory access (rd or wr)
//  mem_ready    memory completes access this cycle
//  hlt_req      HLT decoded in phase 4; halts on the advancing edge
//  phase        current phase 0..7 (the sequencer's observable state)
//  halted, err  latched halt flag, sticky memory-timeout flag
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               step_mode,
  input  logic               step,
  input  logic               resume,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic               hlt_req,
  output logic [PHASE_W-1:0] phase,
  output logic               halted,
  output logic               err
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               halted_q, halted_d;
  logic               err_q, err_d;
  logic               stall, hold, advance;

  always_comb begin
    // mem_req is already masked while halted, so a halt never looks like a stall.
    stall    = mem_req & ~mem_ready;
    hold     = step_mode & (phase_q == PH_FETCH0) & ~step;
    advance  = en & ~halted_q & ~stall & ~hold;

    phase_d  = phase_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    err_d    = err_q;

    if (halted_q) begin
      wait_d = '0;
      if (resume) halted_d = 1'b0;
    end else if (stall) begin
      wait_d = wait_q + 1'b1;
      if (wait_q == WAIT_LAST) begin
        err_d    = 1'b1;
        halted_d = 1'b1;
      end
    end else begin
      wait_d = '0;
      if (advance) begin
        // 3-bit counter wraps 7 -> 0 on its own.
        phase_d = phase_q + 1'b1;
        if (hlt_req) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_FETCH0;
      wait_q   <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign phase  = phase_q;
  assign halted = halted_q;
  assign err    = err_q;

endmodule

// File: rtl/seq_controller.sv
// Self-sequencing CPU control unit: decodes opcode and phase into datapath
// strobes, with memory wait states, timeout, halt/resume and single-step.
// Ports:
//  clk, rst            clock, async active-high reset
//  en, step_mode, step, resume   run control
//  opcode, zero        instruction register opcode, ALU zero flag
//  mem_ready           memory access completes this cycle
//  phase               current phase 0..7
//  sel rd ld_ir halt inc_pc ld_ac wr ld_pc data_e   control strobes
//  err                 sticky memory-timeout error
module seq_controller
  import cpu_pkg::*;
#(
  parameter int OPC_W   = 3,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step_mode,
  input  logic             step,
  input  logic             resume,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       phase,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             ld_pc,
  output logic             data_e,
  output logic             err
);

  logic       halted, err_flag;
  logic       op_known;
  logic [2:0] op;
  logic       is_hlt, is_skz, is_alu, is_sto, is_jmp;
  logic       sel_r, rd_r, ld_ir_r, halt_r, inc_pc_r, ld_ac_r, wr_r, ld_pc_r, data_e_r;

  phase_sequencer #(
    .WAIT_W (WAIT_W),
    .TIMEOUT(TIMEOUT)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .step_mode(step_mode),
    .step     (step),
    .resume   (resume),
    .mem_req  (rd | wr),
    .mem_ready(mem_ready),
    .hlt_req  (halt_r),
    .phase    (phase),
    .halted   (halted),
    .err      (err_flag)
  );

  // Opcodes above 7 behave as NOP: none of the class flags fire.
  always_comb begin
    op_known = ((opcode >> 3) == '0);
    op       = opcode[2:0];
    is_hlt   = op_known & (op == OP_HLT);
    is_skz   = op_known & (op == OP_SKZ);
    is_alu   = op_known & ((op == OP_ADD) | (op == OP_AND) | (op == OP_XOR) | (op == OP_LDA));
    is_sto   = op_known & (op == OP_STO);
    is_jmp   = op_known & (op == OP_JMP);
  end

  always_comb begin
    sel_r    = 1'b0;
    rd_r     = 1'b0;
    ld_ir_r  = 1'b0;
    halt_r   = 1'b0;
    inc_pc_r = 1'b0;
    ld_ac_r  = 1'b0;
    wr_r     = 1'b0;
    ld_pc_r  = 1'b0;
    data_e_r = 1'b0;
    case (phase)
      PH_FETCH0: sel_r = 1'b1;
      PH_FETCH1: begin
        sel_r = 1'b1;
        rd_r  = 1'b1;
      end
      PH_FETCH2, PH_FETCH3: begin
        sel_r   = 1'b1;
        rd_r    = 1'b1;
        ld_ir_r = 1'b1;
      end
      PH_EXEC4: begin
        inc_pc_r = 1'b1;
        halt_r   = is_hlt;
      end
      PH_EXEC5: rd_r = is_alu;
      PH_EXEC6: begin
        rd_r     = is_alu;
        data_e_r = is_sto;
        ld_pc_r  = is_jmp;
        inc_pc_r = is_skz & zero;
      end
      PH_EXEC7: begin
        rd_r     = is_alu;
        ld_ac_r  = is_alu;
        data_e_r = is_sto;
        wr_r     = is_sto;
        ld_pc_r  = is_jmp;
      end
      default: ;
    endcase
  end

  // Reset forces every strobe low immediately (phase 0 would otherwise show sel);
  // a halted core only asserts halt.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    err    = 1'b0;
    if (!rst) begin
      err = err_flag;
      if (halted) begin
        halt = 1'b1;
      end else begin
        sel    = sel_r;
        rd     = rd_r;
        ld_ir  = ld_ir_r;
        halt   = halt_r;
        inc_pc = inc_pc_r;
        ld_ac  = ld_ac_r;
        wr     = wr_r;
        ld_pc  = ld_pc_r;
        data_e = data_e_r;
      end
    end
  end

endmodule
